printer_spool: RTL and testbench
================================

# printer_spool

Buffers bytes the Z80 writes to the printer ports 0xF8–0xFB so the ESP can drain them through the SPI `get_printer_byte` command without holding the Z80 in WAIT on every character. It also answers Z80 status reads on those ports with a TRS-80 printer status byte that shows busy while the buffer is full. It sits between the bus address/data latch stage and the SPI command/response path, and runs in the 84 MHz system domain.

## Interface
Parameters:
- `DEPTH`, 64: buffer depth in bytes; power of two, 4..512.
- `AW`, $clog2(DEPTH): pointer width; derived, never overridden.

Ports:
- `clk`  in  1  system clock (84 MHz).
- `srst`  in  1  synchronous reset, active-high.
- `io_access`  in  1  one-cycle strobe; `trs_a`/`trs_d` are stable in this cycle.
- `trs_a`  in  9  latched port address; bit 8 = 1 means no valid address.
- `trs_d`  in  8  Z80 data bus, already bit-corrected.
- `trs_out_n`  in  1  active-low Z80 OUT cycle.
- `trs_in_n`  in  1  active-low Z80 IN cycle.
- `pop`  in  1  one-cycle request from the SPI command decoder.
- `pop_data`  out  8  dequeued byte; 0x00 when nothing was dequeued.
- `pop_valid`  out  1  one-cycle pulse; `pop_data` holds a real byte.
- `rd_hit`  out  1  combinational; `trs_a[8:2]==7'h3E && !trs_in_n`. Used as the read-mux select and EXTIOSEL term.
- `status_dout`  out  8  printer status byte for Z80 IN.
- `level`  out  AW+1  current occupancy, 0..DEPTH.
- `not_empty`  out  1  level != 0; routed to the ESP as "printer data pending".
- `overflow`  out  1  sticky; set when a byte is dropped.
- `clr_overflow`  in  1  one-cycle clear of `overflow`.

## Operation
- Push condition: `io_access && trs_a[8:2]==7'h3E && !trs_out_n`. All four ports alias; `trs_a[1:0]` is ignored.
- Push when not full: `mem[wr_ptr] <= trs_d`, `wr_ptr++`.
- Push when full and no pop in the same cycle: the byte is discarded, `overflow <= 1`, pointers are unchanged.
- Pop when not empty: read `mem[rd_ptr]`, `rd_ptr++`; the next cycle shows `pop_valid=1` and the byte on `pop_data`.
- Pop when empty: the next cycle shows `pop_valid=0` and `pop_data=0x00`. No pointer change.
- Push and pop in the same cycle:
  - Full: both are accepted, level stays DEPTH, no overflow.
  - Empty: the push is stored, the pop returns empty. There is no bypass path.
  - Otherwise: both are accepted, level is unchanged.
- Pointers are AW bits wide and wrap modulo DEPTH. Full/empty are taken from `level`, not from pointer equality.
- `status_dout = {full, 1'b0, 1'b1, 1'b1, 4'h0}`:
  - 0x30 means ready (not busy, paper present, selected, no fault).
  - 0xB0 means full.
- `clr_overflow` in the same cycle as a dropping push: set wins, `overflow` stays 1.
- Reset values:
  - `wr_ptr`, `rd_ptr`, `level`: 0.
  - `pop_data`: 0x00; `pop_valid`: 0; `overflow`: 0.
  - `status_dout`: 0x30; `not_empty`: 0.
  - Memory contents are not reset.
- Reset during a pending pop: the next cycle shows `pop_valid=0`, `pop_data=0x00`.

## Timing
- Push: accepted on the `io_access` edge. `level`, `not_empty` and `status_dout` update one cycle later.
- Pop latency: 1 cycle (registered BRAM read). `pop_valid` is high for exactly 1 cycle. `pop_data` holds its value until the next pop or reset.
- Throughput: at most one push and one pop per cycle. Z80 writes are ≥100 cycles apart, so the full case matters only when the ESP stalls.
- `rd_hit` is combinational from the inputs, with zero latency, so it can drive the bus mux within the same IN cycle.

## Structure
- Shared package `trs_io_pkg`:
  - `PRINTER_PORT_BASE = 9'h0F8`.
  - `PRN_STAT_BUSY = 7`, `PRN_STAT_PAPER = 6`, `PRN_STAT_SELECT = 5`, `PRN_STAT_FAULT = 4`.
  - `PRN_STAT_READY = 8'h30`.
  - `SPI_CMD_GET_PRINTER_BYTE = 8'd16`.
- Sub-module `sync_fifo #(WIDTH, DEPTH)`: single-clock FIFO with a BRAM-inferred array, registered read, `level` output and simultaneous push/pop rules as above. `printer_spool` wraps it and adds port decode, status and overflow.

## Test plan
- Reset, then Z80 OUT (0xF8, 0x41), then `pop` → next cycle `pop_valid=1`, `pop_data=0x41`, and `level` goes 1→0.
- OUT to 0xF8, 0xF9, 0xFA, 0xFB with 0x01..0x04, then four pops → 0x01, 0x02, 0x03, 0x04 in order; a fifth pop → `pop_valid=0`, `pop_data=0x00`.
- DEPTH+1 writes with no pops → `level=DEPTH`, `status_dout=0xB0`, `overflow=1`, the last byte is lost. One pop → 0x30, and the first byte is returned.
- At full, push and pop in the same cycle → `level` stays DEPTH, `overflow` stays 0, and the pushed byte is the last one drained. Empty plus simultaneous push/pop → `pop_valid=0`, `level=1`.
- IN on 0xFA → `rd_hit=1` and `status_dout=0x30`. IN on 0xF7 or 0xFC, or `trs_a[8]=1` → `rd_hit=0`. OUT on 0xF7 → no push.
- Assert `srst` with 5 bytes queued and a pop in flight → next cycle `level=0`, `pop_valid=0`, `overflow=0`, `status_dout=0x30`. `clr_overflow` together with a dropped push → `overflow` stays 1.

Source files
------------

// File: rtl/trs_io_pkg.sv
// Shared TRS-80 I/O constants: printer port decode, status bit layout
// and the SPI command code the ESP uses to drain the printer spool.
package trs_io_pkg;

    // Base of the four aliased printer ports 0xF8..0xFB (bit 8 = no address).
    localparam logic [8:0] PRINTER_PORT_BASE = 9'h0F8;
    // Address bits that take part in decode; the low two bits alias.
    localparam logic [8:0] PRINTER_PORT_MASK = 9'h1FC;

    // Bit positions inside the TRS-80 printer status byte.
    localparam int PRN_STAT_BUSY   = 7;
    localparam int PRN_STAT_PAPER  = 6;
    localparam int PRN_STAT_SELECT = 5;
    localparam int PRN_STAT_FAULT  = 4;

    // Idle status: not busy, paper present, selected, no fault.
    localparam logic [7:0] PRN_STAT_READY = 8'h30;

    // SPI command that dequeues one printer byte.
    localparam logic [7:0] SPI_CMD_GET_PRINTER_BYTE = 8'd16;

endpackage

// File: rtl/printer_spool_if.sv
// Bus bundle between the Z80 latch stage / SPI decoder (master) and the
// printer spool (slave).
//
// Handshake: io_access is a one-cycle strobe with trs_a/trs_d/trs_*_n
// stable in that cycle; the slave has no ready and always accepts it
// (a write to a full spool is dropped and flagged via overflow). pop is a
// one-cycle request; exactly one cycle later pop_valid pulses for one
// cycle if a byte was dequeued, otherwise pop_valid stays 0 and pop_data
// reads 0x00. pop_data holds until the next pop or reset.
interface printer_spool_if #(
    parameter int DEPTH = 64
);
    logic                     io_access;
    logic [8:0]               trs_a;
    logic [7:0]               trs_d;
    logic                     trs_out_n;
    logic                     trs_in_n;
    logic                     pop;
    logic [7:0]               pop_data;
    logic                     pop_valid;
    logic                     rd_hit;
    logic [7:0]               status_dout;
    logic [$clog2(DEPTH):0]   level;
    logic                     not_empty;
    logic                     overflow;
    logic                     clr_overflow;

    modport master (
        output io_access, trs_a, trs_d, trs_out_n, trs_in_n, pop, clr_overflow,
        input  pop_data, pop_valid, rd_hit, status_dout, level, not_empty, overflow
    );

    modport slave (
        input  io_access, trs_a, trs_d, trs_out_n, trs_in_n, pop, clr_overflow,
        output pop_data, pop_valid, rd_hit, status_dout, level, not_empty, overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a BRAM-style array and registered read port.
// Full/empty come from an explicit occupancy count so pointer equality is
// never ambiguous. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise it is reported on drop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     pop_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    // A pop from an empty FIFO is ignored; there is no bypass of a
    // same-cycle push, so it reads as empty.
    assign do_pop  = pop && !empty;
    // At full a simultaneous pop frees the slot this push lands in.
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    // Storage write; memory contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Registered read: data and valid appear the cycle after the pop.
    always_ff @(posedge clk) begin
        if (srst) begin
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            pop_valid <= do_pop;
            if (do_pop) begin
                pop_data <= mem[rd_ptr];
            end else if (pop) begin
                pop_data <= '0;
            end
        end
    end

endmodule

// File: rtl/printer_spool.sv
// Printer spool: captures Z80 OUTs to ports 0xF8..0xFB into a FIFO the ESP
// drains over SPI, and answers Z80 INs on the same ports with a TRS-80
// printer status byte that reports busy while the spool is full.
module printer_spool
    import trs_io_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  srst,
    printer_spool_if.slave        bus
);
    localparam int AW = $clog2(DEPTH);

    logic          port_sel;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic [AW:0]   fifo_level;
    logic [7:0]    status;

    // All four printer ports alias; masking also rejects bit 8 (no address).
    assign port_sel   = ((bus.trs_a & PRINTER_PORT_MASK) == PRINTER_PORT_BASE);
    assign push       = bus.io_access && port_sel && !bus.trs_out_n;
    // Zero-latency select for the read mux within the same IN cycle.
    assign bus.rd_hit = port_sel && !bus.trs_in_n;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (srst),
        .push      (push),
        .push_data (bus.trs_d),
        .pop       (bus.pop),
        .pop_data  (bus.pop_data),
        .pop_valid (bus.pop_valid),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    // Status byte: ready pattern with busy raised while the spool is full.
    always_comb begin
        status                = PRN_STAT_READY;
        status[PRN_STAT_BUSY] = fifo_full;
    end

    assign bus.status_dout = status;
    assign bus.level       = fifo_level;
    assign bus.not_empty   = !fifo_empty;

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (srst) begin
            bus.overflow <= 1'b0;
        end else if (fifo_drop) begin
            bus.overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            bus.overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_printer_spool.sv
// Bench for printer_spool: directed scenarios followed by random traffic,
// checked against a byte-queue model; pop results go through a scoreboard.
module tb_printer_spool;
    import trs_io_pkg::*;

    localparam int DEPTH = 16;

    logic clk  = 1'b0;
    logic srst = 1'b1;

    always #5 clk = ~clk;

    printer_spool_if #(.DEPTH(DEPTH)) bus ();

    printer_spool #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    logic [8:0] exp_q[$];
    logic [7:0] mq[$];
    bit         m_ovf;
    int         n_checks;
    int         n_err;
    bit         mon_on;
    logic       pend;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit is_printer_port(logic [8:0] a);
        return (a >= 9'h0F8) && (a <= 9'h0FB);
    endfunction

    // Scoreboard monitor: a pop sampled at a posedge must be answered after it.
    always @(posedge clk) pend <= bus.pop;

    always @(negedge clk) begin
        if (mon_on) begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL pop_unexpected: got %0h expected none", {bus.pop_valid, bus.pop_data});
                end else begin
                    chk("pop_result", {bus.pop_valid, bus.pop_data}, exp_q.pop_front());
                end
            end else begin
                chk("pop_idle_valid", bus.pop_valid, 0);
            end
        end
    end

    // One bus cycle: apply inputs, update the model, clock, then check state.
    task automatic step(bit acc, logic [8:0] a, logic [7:0] d, bit out_n, bit in_n,
                        bit p, bit clr, bit rst);
        bit was_full;
        bit dropped;
        bus.io_access    = acc;
        bus.trs_a        = a;
        bus.trs_d        = d;
        bus.trs_out_n    = out_n;
        bus.trs_in_n     = in_n;
        bus.pop          = p;
        bus.clr_overflow = clr;
        srst             = rst;
        if (rst) begin
            if (p) exp_q.push_back(9'h000);
            mq.delete();
            m_ovf = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (p) begin
                if (mq.size() > 0) exp_q.push_back({1'b1, mq.pop_front()});
                else               exp_q.push_back(9'h000);
            end
            dropped = 0;
            if (acc && is_printer_port(a) && !out_n) begin
                if (!was_full || p) mq.push_back(d);
                else begin
                    dropped = 1;
                    m_ovf   = 1;
                end
            end
            if (clr && !dropped) m_ovf = 0;
        end
        #1;
        chk("rd_hit", bus.rd_hit, is_printer_port(a) && !in_n);
        @(posedge clk);
        #1;
        bus.io_access    = 1'b0;
        bus.trs_out_n    = 1'b1;
        bus.trs_in_n     = 1'b1;
        bus.pop          = 1'b0;
        bus.clr_overflow = 1'b0;
        srst             = 1'b0;
        chk("level", bus.level, mq.size());
        chk("not_empty", bus.not_empty, mq.size() != 0);
        chk("overflow", bus.overflow, m_ovf);
        chk("status", bus.status_dout, (mq.size() == DEPTH) ? 8'hB0 : 8'h30);
    endtask

    task automatic z80_out(logic [8:0] a, logic [7:0] d);
        step(1, a, d, 0, 1, 0, 0, 0);
    endtask

    task automatic z80_in(logic [8:0] a);
        step(1, a, 8'h00, 1, 0, 0, 0, 0);
    endtask

    task automatic do_pop();
        step(0, 9'h000, 8'h00, 1, 1, 1, 0, 0);
    endtask

    logic [8:0] addrs [9] = '{9'h0F8, 9'h0F9, 9'h0FA, 9'h0FB, 9'h0F7, 9'h0FC, 9'h1F8, 9'h1FB, 9'h000};

    initial begin
        int pop_pct;
        bus.io_access    = 1'b0;
        bus.trs_a        = 9'h100;
        bus.trs_d        = 8'h00;
        bus.trs_out_n    = 1'b1;
        bus.trs_in_n     = 1'b1;
        bus.pop          = 1'b0;
        bus.clr_overflow = 1'b0;
        n_checks = 0;
        n_err    = 0;
        mon_on   = 0;
        m_ovf    = 0;

        // Clock/reset
        srst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;
        chk("rst_pop_valid", bus.pop_valid, 0);
        chk("rst_pop_data", bus.pop_data, 8'h00);
        chk("rst_level", bus.level, 0);
        chk("rst_not_empty", bus.not_empty, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_status", bus.status_dout, PRN_STAT_READY);
        mon_on = 1;

        // Single byte round trip
        z80_out(9'h0F8, 8'h41);
        do_pop();

        // Four aliased ports, drained in order, then one pop too many
        for (int i = 0; i < 4; i++) z80_out(9'h0F8 + 9'(i), 8'(i + 1));
        for (int i = 0; i < 5; i++) do_pop();

        // Overfill by one: last byte dropped, first byte still at the head
        for (int i = 0; i <= DEPTH; i++) z80_out(9'h0F9, 8'(8'h80 + i));
        chk("fill_overflow", bus.overflow, 1);
        chk("fill_status", bus.status_dout, 8'hB0);
        for (int i = 0; i < DEPTH; i++) do_pop();
        step(0, 9'h000, 8'h00, 1, 1, 0, 1, 0);

        // Full with simultaneous push and pop, then drain
        for (int i = 0; i < DEPTH; i++) z80_out(9'h0FA, 8'(8'h20 + i));
        step(1, 9'h0FB, 8'hEE, 0, 1, 1, 0, 0);
        chk("full_pp_level", bus.level, DEPTH);
        chk("full_pp_overflow", bus.overflow, 0);
        for (int i = 0; i < DEPTH; i++) do_pop();

        // Empty with simultaneous push and pop: no bypass
        step(1, 9'h0F8, 8'h55, 0, 1, 1, 0, 0);
        chk("empty_pp_level", bus.level, 1);
        do_pop();

        // Status reads and decode boundaries
        z80_in(9'h0FA);
        z80_in(9'h0F7);
        z80_in(9'h0FC);
        z80_in(9'h1F8);
        z80_out(9'h0F7, 8'h99);
        z80_out(9'h0FC, 8'h98);
        z80_out(9'h1FA, 8'h97);

        // Reset with bytes queued and a pop issued in the same cycle
        for (int i = 0; i < 5; i++) z80_out(9'h0F8, 8'(8'hA0 + i));
        step(0, 9'h000, 8'h00, 1, 1, 1, 0, 1);

        // Clear collides with a dropping push: set wins
        for (int i = 0; i <= DEPTH; i++) z80_out(9'h0F8, 8'(8'h10 + i));
        step(1, 9'h0F8, 8'h77, 0, 1, 0, 1, 0);
        chk("clr_vs_drop", bus.overflow, 1);
        step(0, 9'h000, 8'h00, 1, 1, 0, 1, 0);

        // Random traffic in phases of differing drain rate
        for (int ph = 0; ph < 6; ph++) begin
            pop_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 85);
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 99) < 60,
                     addrs[$urandom_range(0, 8)],
                     8'($urandom),
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 99) < pop_pct,
                     $urandom_range(0, 49) == 0,
                     $urandom_range(0, 499) == 0);
            end
        end

        repeat (3) step(0, 9'h000, 8'h00, 1, 1, 0, 0, 0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
